// File: rtl/blink_controller_pkg.sv
// Shared definitions for the blink controller and the timer-side bench:
// FSM state codes, level width and default speed parameters.
package blink_controller_pkg;

  localparam int LEVEL_W = 3;

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_LIT     = 2'd1;
  localparam logic [1:0] ST_DARK    = 2'd2;

  localparam int BASE_LOAD_DEF = 31;
  localparam int MAX_LEVEL_DEF = 4;

endpackage

// File: rtl/blink_controller_if.sv
// Signal bundle between the beat/button/timer side (master) and the
// blink controller (slave).
interface blink_controller_if
  import blink_controller_pkg::*;
#(
   parameter int WIDTH = 9
);
   logic               beat;
   logic               run;
   logic               faster;
   logic               slower;
   logic               expired;
   logic               count_en;
   logic [WIDTH-1:0]   load_value;
   logic [LEVEL_W-1:0] level;
   logic               blink;

   modport master (
      output beat, run, faster, slower, expired,
      input  count_en, load_value, level, blink
   );

   modport slave (
      input  beat, run, faster, slower, expired,
      output count_en, load_value, level, blink
   );
endinterface

// File: rtl/blink_controller_level_register.sv
// Saturating speed-level counter; also registers the timer reload value
// BASE_LOAD << level so both change on the same edge.
module blink_controller_level_register
   import blink_controller_pkg::*;
#(
   parameter int WIDTH       = 9,
   parameter int BASE_LOAD   = BASE_LOAD_DEF,
   parameter int MAX_LEVEL   = MAX_LEVEL_DEF,
   parameter int RESET_LEVEL = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               faster,
   input  logic               slower,
   output logic [LEVEL_W-1:0] level,
   output logic [WIDTH-1:0]   load_value
);

   localparam logic [LEVEL_W-1:0] TOP_LVL = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] RST_LVL = LEVEL_W'(RESET_LEVEL);
   localparam logic [WIDTH-1:0]   BASE    = WIDTH'(BASE_LOAD);

   logic [LEVEL_W-1:0] level_next;

   // NOTE: level_next gets a default before any branch so no latch is inferred.
   always_comb begin
      level_next = level;
      if (faster && !slower && level != '0)
         level_next = level - LEVEL_W'(1);
      else if (slower && !faster && level != TOP_LVL)
         level_next = level + LEVEL_W'(1);
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level      <= RST_LVL;
         load_value <= BASE << RST_LVL;
      end else begin
         level      <= level_next;
         load_value <= BASE << level_next;
      end
   end

endmodule

// File: rtl/blink_controller.sv
// Gates the beat into the timer count enable, supplies the reload value from
// the speed level, and runs the LIT/DARK blink FSM off the timer expiry.
module blink_controller
   import blink_controller_pkg::*;
#(
   parameter int WIDTH       = 9,
   parameter int BASE_LOAD   = BASE_LOAD_DEF,
   parameter int MAX_LEVEL   = MAX_LEVEL_DEF,
   parameter int DEFAULT_LVL = 2,
   parameter int DARK_BEATS  = 2
) (
   input  logic              clock,
   input  logic              reset,
   blink_controller_if.slave bus
);

   localparam int              DC_W    = (DARK_BEATS > 1) ? $clog2(DARK_BEATS) : 1;
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DARK_BEATS - 1);

   logic [1:0]      state;
   logic [1:0]      state_next;
   logic [DC_W-1:0] dark_cnt;
   logic [DC_W-1:0] dark_cnt_next;

   blink_controller_level_register #(
      .WIDTH       (WIDTH),
      .BASE_LOAD   (BASE_LOAD),
      .MAX_LEVEL   (MAX_LEVEL),
      .RESET_LEVEL (DEFAULT_LVL)
   ) u_level (
      .clock      (clock),
      .reset      (reset),
      .faster     (bus.faster),
      .slower     (bus.slower),
      .level      (bus.level),
      .load_value (bus.load_value)
   );

   // run=0 is checked before expired in every running state.
   always_comb begin
      state_next    = state;
      dark_cnt_next = dark_cnt;
      case (state)
         ST_STOPPED: begin
            if (bus.run) begin
               state_next    = ST_LIT;
               dark_cnt_next = '0;
            end
         end
         ST_LIT: begin
            if (!bus.run) begin
               state_next = ST_STOPPED;
            end else if (bus.expired) begin
               state_next    = ST_DARK;
               dark_cnt_next = '0;
            end
         end
         ST_DARK: begin
            if (!bus.run) begin
               state_next = ST_STOPPED;
            end else if (bus.expired) begin
               if (dark_cnt == DC_LAST)
                  state_next = ST_LIT;
               else
                  dark_cnt_next = dark_cnt + DC_W'(1);
            end
         end
         default: state_next = ST_STOPPED;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_STOPPED;
         dark_cnt <= '0;
      end else begin
         state    <= state_next;
         dark_cnt <= dark_cnt_next;
      end
   end

   assign bus.count_en = bus.beat & bus.run & (state != ST_STOPPED);
   assign bus.blink    = (state == ST_LIT);

endmodule
